// File: rtl/cw305_prog_bridge_ctrl.sv
// cw305_prog_bridge_ctrl: program-load sequencer between the USB register
// file and the X-HEEP memory bus (OBI-style req/gnt/rvalid, write only).
// Ports: usb_clk, reset_i (sync, active high); I_status/I_instruction/
//   I_address from the register file; O_reset_* active-low flag-clear
//   strobes; O_bus_* / I_bus_* memory bus; O_busy, O_error, O_word_count.
// Optional: define PROG_BRIDGE_TIMEOUT_EN to add a per-phase bus watchdog
//   that aborts to ERROR after pTIMEOUT_CYCLES cycles without gnt/rvalid.
module cw305_prog_bridge_ctrl #(
    parameter int pINSTR_WIDTH    = 32,
    parameter int pCOUNT_WIDTH    = 16,
    parameter int pTIMEOUT_CYCLES = 255
) (
    input  logic                    usb_clk,
    input  logic                    reset_i,
    input  logic [7:0]              I_status,
    input  logic [pINSTR_WIDTH-1:0] I_instruction,
    input  logic [pINSTR_WIDTH-1:0] I_address,
    output logic                    O_reset_new_addr_valid,
    output logic                    O_reset_instr_valid,
    output logic                    O_bus_req,
    output logic                    O_bus_we,
    output logic [3:0]              O_bus_be,
    output logic [pINSTR_WIDTH-1:0] O_bus_addr,
    output logic [pINSTR_WIDTH-1:0] O_bus_wdata,
    input  logic                    I_bus_gnt,
    input  logic                    I_bus_rvalid,
    output logic                    O_busy,
    output logic                    O_error,
    output logic [pCOUNT_WIDTH-1:0] O_word_count
);

    localparam int W  = pINSTR_WIDTH;
    localparam int TW = $clog2(pTIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ADDR,
        REQ,
        WAIT_RVALID,
        ACK,
        WAIT_CLR,
        ERROR
    } state_t;

    state_t                  state_q;
    logic                    strb_addr_q;
    logic                    strb_instr_q;
    logic                    sel_addr_q;
    logic                    req_q;
    logic                    we_q;
    logic [3:0]              be_q;
    logic [W-1:0]            addr_q;
    logic [W-1:0]            wdata_q;
    logic                    err_q;
    logic [pCOUNT_WIDTH-1:0] cnt_q;

    // Only the three low status bits carry meaning.
    logic unused_status;
    assign unused_status = ^I_status[7:3];

`ifdef PROG_BRIDGE_TIMEOUT_EN
    logic [TW-1:0] tmo_q;
    localparam logic [TW-1:0] TMO_LAST = TW'(pTIMEOUT_CYCLES - 1);
`else
    logic [TW-1:0] unused_tmo;
    assign unused_tmo = TW'(pTIMEOUT_CYCLES);
`endif

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state_q      <= IDLE;
            strb_addr_q  <= 1'b1;
            strb_instr_q <= 1'b1;
            sel_addr_q   <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
`ifdef PROG_BRIDGE_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (I_status[0]) begin
                        if (I_status[2]) begin
                            state_q <= LOAD_ADDR;
                        end else if (I_status[1]) begin
                            state_q    <= REQ;
                            req_q      <= 1'b1;
                            we_q       <= 1'b1;
                            be_q       <= 4'hF;
                            wdata_q    <= I_instruction;
                            sel_addr_q <= 1'b0;
`ifdef PROG_BRIDGE_TIMEOUT_EN
                            tmo_q      <= '0;
`endif
                        end
                    end
                end
                LOAD_ADDR: begin
                    addr_q     <= {I_address[W-1:2], 2'b00};
                    cnt_q      <= '0;
                    sel_addr_q <= 1'b1;
                    state_q    <= ACK;
                end
                REQ: begin
                    if (I_bus_gnt) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= 4'h0;
                        state_q <= WAIT_RVALID;
`ifdef PROG_BRIDGE_TIMEOUT_EN
                        tmo_q   <= '0;
                    end else if (tmo_q == TMO_LAST) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= 4'h0;
                        err_q   <= 1'b1;
                        state_q <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                WAIT_RVALID: begin
                    if (I_bus_rvalid) begin
                        addr_q  <= addr_q + W'(4);
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        state_q <= ACK;
`ifdef PROG_BRIDGE_TIMEOUT_EN
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                ACK: begin
                    if (sel_addr_q) strb_addr_q  <= 1'b0;
                    else            strb_instr_q <= 1'b0;
                    state_q <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    strb_addr_q  <= 1'b1;
                    strb_instr_q <= 1'b1;
                    // The register file drops the flag a cycle after the
                    // strobe; leaving earlier would service it twice.
                    if (sel_addr_q ? !I_status[2] : !I_status[1])
                        state_q <= IDLE;
                end
                ERROR: begin
                    if (!I_status[0]) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign O_reset_new_addr_valid = strb_addr_q;
    assign O_reset_instr_valid    = strb_instr_q;
    assign O_bus_req              = req_q;
    assign O_bus_we               = we_q;
    assign O_bus_be               = be_q;
    assign O_bus_addr             = addr_q;
    assign O_bus_wdata            = wdata_q;
    assign O_busy                 = (state_q != IDLE);
    assign O_error                = err_q;
    assign O_word_count           = cnt_q;

endmodule

// File: tb/tb_cw305_prog_bridge_ctrl.sv
// tb_cw305_prog_bridge_ctrl: directed bench for the program-load sequencer.
// Models the register file flag clearing and a one-cycle-latency bus slave.
module tb_cw305_prog_bridge_ctrl;

    localparam int W  = 32;
    localparam int CW = 2;

    logic          usb_clk = 1'b0;
    logic          reset_i;
    logic [7:0]    I_status;
    logic [W-1:0]  I_instruction;
    logic [W-1:0]  I_address;
    logic          O_reset_new_addr_valid;
    logic          O_reset_instr_valid;
    logic          O_bus_req;
    logic          O_bus_we;
    logic [3:0]    O_bus_be;
    logic [W-1:0]  O_bus_addr;
    logic [W-1:0]  O_bus_wdata;
    logic          I_bus_gnt;
    logic          I_bus_rvalid;
    logic          O_busy;
    logic          O_error;
    logic [CW-1:0] O_word_count;

    cw305_prog_bridge_ctrl #(
        .pINSTR_WIDTH   (W),
        .pCOUNT_WIDTH   (CW),
        .pTIMEOUT_CYCLES(255)
    ) dut (
        .usb_clk               (usb_clk),
        .reset_i               (reset_i),
        .I_status              (I_status),
        .I_instruction         (I_instruction),
        .I_address             (I_address),
        .O_reset_new_addr_valid(O_reset_new_addr_valid),
        .O_reset_instr_valid   (O_reset_instr_valid),
        .O_bus_req             (O_bus_req),
        .O_bus_we              (O_bus_we),
        .O_bus_be              (O_bus_be),
        .O_bus_addr            (O_bus_addr),
        .O_bus_wdata           (O_bus_wdata),
        .I_bus_gnt             (I_bus_gnt),
        .I_bus_rvalid          (I_bus_rvalid),
        .O_busy                (O_busy),
        .O_error               (O_error),
        .O_word_count          (O_word_count)
    );

    always #5 usb_clk = ~usb_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus slave: grant one cycle after req, rvalid one cycle after grant.
    logic         hold = 1'b0;
    logic [31:0]  wa_q[$];
    logic [31:0]  wd_q[$];
    logic [4:0]   wm_q[$];

    always @(posedge usb_clk) begin
        if (reset_i) begin
            I_bus_gnt    <= 1'b0;
            I_bus_rvalid <= 1'b0;
        end else begin
            I_bus_rvalid <= O_bus_req && I_bus_gnt;
            I_bus_gnt    <= O_bus_req && !I_bus_gnt && !hold;
            if (O_bus_req && I_bus_gnt) begin
                wa_q.push_back(O_bus_addr);
                wd_q.push_back(O_bus_wdata);
                wm_q.push_back({O_bus_we, O_bus_be});
            end
        end
    end

    // Drive status, count strobes, clear each flag a cycle after its strobe.
    task automatic run_op(input logic [7:0] st, output int n_a,
                          output int n_i, output int lat_a,
                          output int lat_i);
        bit clr_a = 0;
        bit clr_i = 0;
        bit done  = 0;
        n_a = 0; n_i = 0; lat_a = 0; lat_i = 0;
        I_status = st;
        for (int t = 1; t <= 80 && !done; t++) begin
            @(posedge usb_clk); #1;
            if (clr_a) begin I_status[2] = 1'b0; clr_a = 0; end
            if (clr_i) begin I_status[1] = 1'b0; clr_i = 0; end
            if (!O_reset_new_addr_valid) begin
                n_a++;
                if (lat_a == 0) lat_a = t;
                clr_a = 1;
            end
            if (!O_reset_instr_valid) begin
                n_i++;
                if (lat_i == 0) lat_i = t;
                clr_i = 1;
            end
            if (I_status[2:1] == 2'b00 && !O_busy && !clr_a && !clr_i)
                done = 1;
        end
        check("op_done", 32'(done), 32'd1);
    endtask

    task automatic chk_write(input string tag, input logic [31:0] ea,
                             input logic [31:0] ed);
        logic [31:0] a = 'x;
        logic [31:0] d = 'x;
        logic [4:0]  m = 'x;
        if (wa_q.size() > 0) begin
            a = wa_q.pop_front();
            d = wd_q.pop_front();
            m = wm_q.pop_front();
        end
        check({tag, "_addr"}, a, ea);
        check({tag, "_data"}, d, ed);
        check({tag, "_we_be"}, 32'(m), 32'h1F);
    endtask

    task automatic do_write(input string tag, input logic [31:0] d,
                            input logic [31:0] ea);
        int na, ni, la, li;
        I_instruction = d;
        run_op(8'h03, na, ni, la, li);
        check({tag, "_nstrb_i"}, 32'(ni), 32'd1);
        check({tag, "_nstrb_a"}, 32'(na), 32'd0);
        chk_write(tag, ea, d);
        I_status = 8'h01;
    endtask

    logic [31:0] words [3];
    int na, ni, la, li;

    initial begin
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h00000013;
        words[2] = 32'h12345678;
        reset_i = 1'b1;
        I_status = 8'h00;
        I_instruction = '0;
        I_address = '0;
        repeat (3) @(posedge usb_clk);
        #1 reset_i = 1'b0;

        check("rst_req", 32'(O_bus_req), 32'd0);
        check("rst_we", 32'(O_bus_we), 32'd0);
        check("rst_be", 32'(O_bus_be), 32'd0);
        check("rst_addr", O_bus_addr, 32'd0);
        check("rst_wdata", O_bus_wdata, 32'd0);
        check("rst_strb_a", 32'(O_reset_new_addr_valid), 32'd1);
        check("rst_strb_i", 32'(O_reset_instr_valid), 32'd1);
        check("rst_busy", 32'(O_busy), 32'd0);
        check("rst_err", 32'(O_error), 32'd0);
        check("rst_cnt", 32'(O_word_count), 32'd0);

        // Address load with misaligned start, strobe two cycles after sample.
        I_address = 32'h0000_1003;
        run_op(8'h05, na, ni, la, li);
        check("ld_nstrb_a", 32'(na), 32'd1);
        check("ld_nstrb_i", 32'(ni), 32'd0);
        check("ld_lat", 32'(la), 32'd3);
        check("ld_cnt", 32'(O_word_count), 32'd0);
        I_status = 8'h01;

        // First write also checks minimum turnaround.
        I_instruction = words[0];
        run_op(8'h03, na, ni, la, li);
        check("w0_lat", 32'(li), 32'd5);
        check("w0_nstrb_i", 32'(ni), 32'd1);
        chk_write("w0", 32'h1000, words[0]);
        I_status = 8'h01;
        do_write("w1", words[1], 32'h1004);
        do_write("w2", words[2], 32'h1008);
        check("w_cnt", 32'(O_word_count), 32'd3);
        check("w_next", O_bus_addr, 32'h100C);

        // Reset while a request is outstanding.
        hold = 1'b1;
        I_status = 8'h03;
        repeat (3) begin @(posedge usb_clk); #1; end
        check("mid_req", 32'(O_bus_req), 32'd1);
        reset_i = 1'b1;
        @(posedge usb_clk); #1;
        check("mrst_req", 32'(O_bus_req), 32'd0);
        check("mrst_strb_a", 32'(O_reset_new_addr_valid), 32'd1);
        check("mrst_strb_i", 32'(O_reset_instr_valid), 32'd1);
        check("mrst_busy", 32'(O_busy), 32'd0);
        check("mrst_cnt", 32'(O_word_count), 32'd0);
        reset_i = 1'b0;
        I_status = 8'h00;
        hold = 1'b0;
        @(posedge usb_clk); #1;

        // Address and instruction flags together: address first.
        I_address = 32'h0000_2000;
        I_instruction = 32'hAAAA5555;
        run_op(8'h07, na, ni, la, li);
        check("both_nstrb_a", 32'(na), 32'd1);
        check("both_nstrb_i", 32'(ni), 32'd1);
        check("both_lat_a", 32'(la), 32'd3);
        check("both_order", 32'(la < li), 32'd1);
        chk_write("both", 32'h2000, 32'hAAAA5555);
        check("both_cnt", 32'(O_word_count), 32'd1);
        I_status = 8'h01;

        // Address wrap at the top of the space.
        I_address = 32'hFFFF_FFFF;
        run_op(8'h05, na, ni, la, li);
        I_status = 8'h01;
        do_write("wrap", 32'h0000_0001, 32'hFFFF_FFFC);
        check("wrap_next", O_bus_addr, 32'h0);

        // Word counter saturates at all-ones.
        do_write("s1", 32'h11, 32'h0);
        do_write("s2", 32'h22, 32'h4);
        check("sat_full", 32'(O_word_count), 32'd3);
        do_write("s3", 32'h33, 32'h8);
        check("sat_hold", 32'(O_word_count), 32'd3);

        // No transfer starts while program mode is off.
        I_status = 8'h02;
        repeat (5) begin @(posedge usb_clk); #1; end
        check("off_busy", 32'(O_busy), 32'd0);
        check("off_req", 32'(O_bus_req), 32'd0);

        // Program mode dropped mid-transfer: the write still completes.
        hold = 1'b1;
        I_instruction = 32'h0000_0055;
        I_status = 8'h03;
        repeat (2) begin @(posedge usb_clk); #1; end
        hold = 1'b0;
        run_op(8'h02, na, ni, la, li);
        check("drop_nstrb_i", 32'(ni), 32'd1);
        chk_write("drop", 32'hC, 32'h55);
        I_status = 8'h00;

`ifdef PROG_BRIDGE_TIMEOUT_EN
        begin
            int hi = 0;
            int lo = 0;
            bit fell = 0;
            hold = 1'b1;
            I_status = 8'h03;
            for (int t = 0; t < 300 && !fell; t++) begin
                @(posedge usb_clk); #1;
                if (!O_reset_instr_valid) lo++;
                if (O_bus_req) hi++;
                else if (hi > 0) fell = 1;
            end
            check("tmo_req_cycles", 32'(hi), 32'd255);
            check("tmo_req", 32'(O_bus_req), 32'd0);
            check("tmo_err", 32'(O_error), 32'd1);
            check("tmo_busy", 32'(O_busy), 32'd1);
            check("tmo_nstrb", 32'(lo), 32'd0);
            I_status = 8'h00;
            repeat (2) begin @(posedge usb_clk); #1; end
            check("tmo_idle", 32'(O_busy), 32'd0);
            check("tmo_err_sticky", 32'(O_error), 32'd1);
            hold = 1'b0;
        end
`endif

        check("no_extra_writes", 32'(wa_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cw305_prog_bridge_ctrl.md
# cw305_prog_bridge_ctrl

Sequencer between the USB register file and the X-HEEP memory bus for loading programs. It watches the bridge status byte for new-address and new-instruction flags. It writes each instruction word to memory over an OBI-style request/grant/rvalid handshake, auto-incrementing the address by 4. It returns active-low flag-clear strobes to the register file and exposes busy, error and word-count status.

## Interface
- pINSTR_WIDTH, 32, instruction/address/data width
- pCOUNT_WIDTH, 16, width of the written-word counter
- pTIMEOUT_CYCLES, 255, watchdog limit per bus phase (used only with PROG_BRIDGE_TIMEOUT_EN)

Ports:
- usb_clk  in  1  sole clock; all logic on the rising edge
- reset_i  in  1  synchronous, active-high reset
- I_status  in  8  bridge status byte: [0] program-mode enable, [1] instruction valid, [2] address valid
- I_instruction  in  pINSTR_WIDTH  instruction word from the register file
- I_address  in  pINSTR_WIDTH  start byte address from the register file
- O_reset_new_addr_valid  out  1  active-low one-cycle strobe that clears status[2]
- O_reset_instr_valid  out  1  active-low one-cycle strobe that clears status[1]
- O_bus_req  out  1  bus request
- O_bus_we  out  1  write enable; 1 whenever req is 1
- O_bus_be  out  4  byte enables; 4'hF whenever req is 1
- O_bus_addr  out  pINSTR_WIDTH  word-aligned byte address
- O_bus_wdata  out  pINSTR_WIDTH  write data
- I_bus_gnt  in  1  grant
- I_bus_rvalid  in  1  response valid
- O_busy  out  1  FSM not in IDLE
- O_error  out  1  sticky error flag
- O_word_count  out  pCOUNT_WIDTH  words written since the last address load; saturates at all-ones

## Operation
- Reset values:
  - FSM in IDLE.
  - Both strobes 1.
  - O_bus_req, O_bus_we, O_busy and O_error are 0.
  - O_bus_be, O_bus_addr, O_bus_wdata and O_word_count are 0.
  - The internal address register is 0.
- States: IDLE, LOAD_ADDR, REQ, WAIT_RVALID, ACK, WAIT_CLR, ERROR.
- IDLE: acts only when status[0]=1.
  - status[2]=1 → LOAD_ADDR. This has priority when status[2] and status[1] are both set.
  - Otherwise status[1]=1 → REQ.
- LOAD_ADDR (1 cycle):
  - Address register ← I_address with bits [1:0] forced to 0.
  - Word count cleared.
  - Go to ACK with the address strobe selected.
- REQ:
  - Drive req=1, addr = address register, wdata = I_instruction (captured on REQ entry), we=1, be=4'hF.
  - Hold until gnt=1, then go to WAIT_RVALID with req=0 from the next cycle.
- WAIT_RVALID: hold until rvalid=1, then:
  - Address register += 4, wrapping modulo 2^pINSTR_WIDTH.
  - Word count +1, saturating.
  - Go to ACK with the instruction strobe selected.
- ACK (1 cycle): drive the selected strobe low, then go to WAIT_CLR.
- WAIT_CLR: wait until the serviced flag reads 0, then go to IDLE. This prevents the same flag being serviced twice, since the register file clears it one cycle after the strobe.
- status[0] falling mid-transfer: the in-flight bus transaction always completes and is not aborted. The FSM then returns to IDLE through ACK/WAIT_CLR as normal. No new transfer starts while status[0]=0.
- ERROR: exits only when status[0]=0, then goes to IDLE. O_error stays set until reset_i.
- Reset during any state: all outputs return to their reset values in the cycle after reset_i is sampled high.

## Timing
- Status flag sampled high in IDLE at edge N → O_bus_req=1 from edge N+1.
- gnt sampled at edge M → req low after M.
- rvalid sampled at edge R → address/count update at R, strobe low for exactly one cycle after R+1.
- Minimum instruction turnaround, with gnt and rvalid each one cycle after request: 5 cycles from flag set to strobe, plus WAIT_CLR.
- Address load: strobe low two cycles after the flag is sampled.
- Strobes are registered outputs, never combinational.

## Configuration
- PROG_BRIDGE_TIMEOUT_EN:
  - Defined: a per-state counter runs in REQ and WAIT_RVALID. If it reaches pTIMEOUT_CYCLES without gnt/rvalid:
    - req is forced to 0;
    - O_error is set;
    - the FSM goes to ERROR;
    - no strobe is issued.
  - Undefined: no counter; REQ and WAIT_RVALID wait indefinitely, and the ERROR state is unreachable.

## Test plan
- Reset mid-REQ → next cycle: req=0, both strobes=1, O_busy=0, O_word_count=0.
- status=8'h05, I_address=32'h0000_1003 → O_reset_new_addr_valid low for one cycle. A following write lands at 32'h0000_1000.
- Three instructions 32'hDEADBEEF, 32'h00000013, 32'h12345678, gnt/rvalid after 1 cycle, after address 32'h1000 → bus writes at 32'h1000, 32'h1004, 32'h1008; O_word_count=3; one instruction strobe per word.
- status=8'h07 (address and instruction both set) → address serviced first, then the instruction is written at the new address.
- Address register 32'hFFFF_FFFC, one write → next address 32'h0000_0000. Separately, O_word_count at all-ones stays all-ones after another write.
- With PROG_BRIDGE_TIMEOUT_EN, gnt held 0 → after 255 cycles req=0 and O_error=1. Clearing status[0] returns the FSM to IDLE with O_error still 1.
